// File: rtl/data_memory_access_unit.sv
// MEM-stage load/store responder: req/ack handshake to data memory with lane steering,
// load extension, fault detection and a timeout. Optional one-word read buffer: DMAU_READ_BUFFER_EN.
module data_memory_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [3:0]  mem_read,
  input  logic [2:0]  mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busywait,
  output logic        mem_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic              ld_q;

  logic              load_en, store_en, req_any;
  logic [1:0]        size;
  logic              reserved, misalign, fault_in, buf_hit, timeout;
  logic [3:0]        be_in;
  logic [31:0]       wdata_in;

  function automatic logic [31:0] extract(input logic [2:0]  f3,
                                          input logic [1:0]  lane,
                                          input logic [31:0] word);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'b0, b};
      3'b101:  extract = {16'b0, h};
      default: extract = word;
    endcase
  endfunction

  assign load_en  = mem_read[3];
  assign store_en = mem_write[2];
  assign req_any  = load_en | store_en;
  assign timeout  = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    size     = 2'b00;
    reserved = 1'b0;
    if (load_en) begin
      size     = mem_read[1:0];
      reserved = (mem_read[1:0] == 2'b11) | (mem_read[2] & mem_read[1]);
    end else begin
      size     = mem_write[1:0];
      reserved = (mem_write[1:0] == 2'b11);
    end
    misalign = ((size == 2'b01) & address[0]) | ((size == 2'b10) & (address[1:0] != 2'b00));
    fault_in = reserved | misalign | (load_en & store_en);

    case (size)
      2'b00:   be_in = 4'b0001 << address[1:0];
      2'b01:   be_in = address[1] ? 4'b1100 : 4'b0011;
      2'b10:   be_in = 4'b1111;
      default: be_in = 4'b0000;
    endcase

    case (mem_write[1:0])
      2'b00:   wdata_in = {4{write_data[7:0]}};
      2'b01:   wdata_in = {2{write_data[15:0]}};
      default: wdata_in = write_data;
    endcase
  end

`ifdef DMAU_READ_BUFFER_EN
  logic        buf_valid_q;
  logic [29:0] buf_addr_q;
  logic [31:0] buf_word_q;

  assign buf_hit = load_en & ~store_en & ~fault_in & buf_valid_q &
                   (address[31:2] == buf_addr_q);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_word_q  <= '0;
    end else begin
      case (state_q)
        StIdle: if (req_any && fault_in) buf_valid_q <= 1'b0;
        StAccess: begin
          if (mem_ack) begin
            buf_valid_q <= ld_q;
            if (ld_q) begin
              buf_addr_q <= mem_addr[31:2];
              buf_word_q <= mem_rdata;
            end
          end else if (timeout) begin
            buf_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_any) state_d = (fault_in | buf_hit) ? StDone : StAccess;
      end
      StAccess: if (mem_ack || timeout) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Stall is combinational so the pipeline freezes in the same cycle the request appears.
  always_comb begin
    busywait = 1'b0;
    case (state_q)
      StIdle:   busywait = req_any;
      StAccess: busywait = 1'b1;
      default:  busywait = 1'b0;
    endcase
    busywait = busywait & RESETn;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      read_data <= '0;
      mem_fault <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      cnt_q     <= '0;
      f3_q      <= '0;
      lane_q    <= '0;
      ld_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_any) begin
            mem_we    <= store_en;
            mem_addr  <= {address[31:2], 2'b00};
            mem_be    <= be_in;
            mem_wdata <= wdata_in;
            f3_q      <= mem_read[2:0];
            lane_q    <= address[1:0];
            ld_q      <= load_en;
            cnt_q     <= '0;
            if (fault_in) begin
              mem_fault <= 1'b1;
              read_data <= '0;
            end else if (buf_hit) begin
              mem_fault <= 1'b0;
`ifdef DMAU_READ_BUFFER_EN
              read_data <= extract(mem_read[2:0], address[1:0], buf_word_q);
`endif
            end else begin
              mem_req <= 1'b1;
            end
          end
        end
        StAccess: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_fault <= 1'b0;
            read_data <= ld_q ? extract(f3_q, lane_q, mem_rdata) : 32'h0;
          end else if (timeout) begin
            mem_req   <= 1'b0;
            mem_fault <= 1'b1;
            read_data <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
